// File: rtl/prime_check.sv
// Iterative primality tester: trial division by odd divisors, each remainder
// produced by a W-cycle bit-serial restoring divider.
module prime_check #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] n,
    output logic         ready,
    output logic         is_prime,
    output logic         error
);

    localparam int CNT_W = $clog2(W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_DIV   = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     n_q;
    logic [W-1:0]     d;
    logic [2*W-1:0]   sq;
    logic [W-1:0]     rem;
    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0]     rem_nxt;
    logic             sq_gt_n;
    logic             last_bit;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [W-1:0] div_step(input logic [W-1:0] r,
                                              input logic         b,
                                              input logic [W-1:0] dv);
        logic [W:0] t;
        t = {r, b};
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
        end
        return t[W-1:0];
    endfunction

    assign ready    = (state == S_IDLE);
    assign rem_nxt  = div_step(rem, shreg[W-1], d);
    assign sq_gt_n  = (sq > {{W{1'b0}}, n_q});
    assign last_bit = (cnt == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            n_q      <= '0;
            d        <= '0;
            sq       <= '0;
            rem      <= '0;
            shreg    <= '0;
            cnt      <= '0;
            is_prime <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        n_q      <= n;
                        d        <= W'(3);
                        sq       <= (2*W)'(9);
                        is_prime <= 1'b0;
                        error    <= 1'b0;
                        state    <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (n_q < W'(2)) begin
                        error    <= 1'b1;
                        is_prime <= 1'b0;
                        state    <= S_IDLE;
                    end else if (n_q == W'(2)) begin
                        is_prime <= 1'b1;
                        state    <= S_IDLE;
                    end else if (!n_q[0]) begin
                        is_prime <= 1'b0;
                        state    <= S_IDLE;
                    end else if (sq_gt_n) begin
                        is_prime <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        rem   <= '0;
                        shreg <= n_q;
                        cnt   <= '0;
                        state <= S_DIV;
                    end
                end

                S_DIV: begin
                    rem   <= rem_nxt;
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        if (rem_nxt == '0) begin
                            is_prime <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            // (d+2)^2 = d^2 + 4d + 4, using the old d
                            d     <= d + W'(2);
                            sq    <= sq + {{(W-2){1'b0}}, d, 2'b00} + (2*W)'(4);
                            state <= S_CHECK;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_check.sv
// Randomized and directed bench for prime_check (W=16) against a plain
// trial-division reference model.
module tb_prime_check;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         go;
    logic [W-1:0] n;
    logic         ready;
    logic         is_prime;
    logic         error;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor / model state
    bit in_run   = 0;
    bit have_res = 0;
    int busy     = 0;
    int exp_busy = 0;
    int exp_p    = 0;
    int exp_e    = 0;
    int last_busy = -1;
    int last_p    = -1;
    int last_e    = -1;

    prime_check #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .n        (n),
        .ready    (ready),
        .is_prime (is_prime),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: result and busy time straight from the trial-division rules.
    function automatic void model(input int v, output int p, output int e, output int b);
        int j;
        e = 0;
        p = 0;
        b = 1;
        if (v < 2) begin
            e = 1;
        end else if (v == 2) begin
            p = 1;
        end else if (v % 2 == 0) begin
            p = 0;
        end else begin
            j = 0;
            p = 1;
            for (int dv = 3; dv * dv <= v; dv += 2) begin
                j++;
                if (v % dv == 0) begin
                    p = 0;
                    break;
                end
            end
            b = p ? 1 + j * (W + 1) : j * (W + 1);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", int'(ready), 1);
            chk("rst_is_prime", int'(is_prime), 0);
            chk("rst_error", int'(error), 0);
            in_run   = 0;
            have_res = 0;
        end else begin
            chk("exclusive", int'(is_prime & error), 0);
            if (in_run) begin
                if (!ready) begin
                    busy++;
                    chk("busy_is_prime", int'(is_prime), 0);
                    chk("busy_error", int'(error), 0);
                end else begin
                    chk("busy_cycles", busy, exp_busy);
                    chk("result_is_prime", int'(is_prime), exp_p);
                    chk("result_error", int'(error), exp_e);
                    last_busy = busy;
                    last_p    = int'(is_prime);
                    last_e    = int'(error);
                    in_run    = 0;
                    have_res  = 1;
                end
            end else begin
                chk("idle_ready", int'(ready), 1);
                chk("hold_is_prime", int'(is_prime), have_res ? exp_p : 0);
                chk("hold_error", int'(error), have_res ? exp_e : 0);
            end
            if (ready && go) begin
                model(int'(n), exp_p, exp_e, exp_busy);
                in_run = 1;
                busy   = 0;
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 5000);
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ready stuck at 0 after %0d cycles", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input logic [W-1:0] v);
        @(posedge clk);
        #1;
        go = 1'b1;
        n  = v;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_ready();
    endtask

    task automatic directed(input logic [W-1:0] v, input int b, input int p, input int e);
        do_run(v);
        chk($sformatf("dir_busy_%0d", v), last_busy, b);
        chk($sformatf("dir_prime_%0d", v), last_p, p);
        chk($sformatf("dir_err_%0d", v), last_e, e);
    endtask

    initial begin
        int mp, me, mb;
        logic [W-1:0] v;

        go    = 1'b0;
        n     = '0;
        rst_n = 1'b0;

        // Pin the reference model with hand-derived values.
        model(97, mp, me, mb);
        chk("model_97_busy", mb, 69);
        chk("model_97_prime", mp, 1);
        model(91, mp, me, mb);
        chk("model_91_busy", mb, 51);
        chk("model_91_prime", mp, 0);
        model(65521, mp, me, mb);
        chk("model_65521_busy", mb, 2160);
        model(1, mp, me, mb);
        chk("model_1_error", me, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", int'(ready), 1);
        chk("reset_is_prime", int'(is_prime), 0);
        chk("reset_error", int'(error), 0);

        // First request lands on the first edge after release.
        go    = 1'b1;
        n     = 16'd2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_ready();
        chk("first_busy_2", last_busy, 1);
        chk("first_prime_2", last_p, 1);
        chk("first_err_2", last_e, 0);

        directed(16'd97, 69, 1, 0);
        directed(16'd91, 51, 0, 0);
        directed(16'd65521, 2160, 1, 0);
        directed(16'd65535, 17, 0, 0);
        directed(16'd0, 1, 0, 1);
        directed(16'd1, 1, 0, 1);
        directed(16'd4, 1, 0, 0);
        directed(16'd3, 1, 1, 0);
        directed(16'd9, 17, 0, 0);

        // Reset 10 cycles into a run of 97.
        @(posedge clk);
        #1;
        go = 1'b1;
        n  = 16'd97;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_run_busy", int'(ready), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_is_prime", int'(is_prime), 0);
        chk("abort_error", int'(error), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_is_prime", int'(is_prime), 0);

        // go held through a run (n changes mid-run), then back-to-back accept.
        @(posedge clk);
        #1;
        go = 1'b1;
        n  = 16'd97;
        @(posedge clk);
        #1;
        n = 16'd4;
        wait_ready();
        chk("held_go_busy", last_busy, 69);
        chk("held_go_prime", last_p, 1);
        go = 1'b0;
        wait_ready();
        chk("b2b_busy", last_busy, 1);
        chk("b2b_prime", last_p, 0);

        // Randomized candidates, mostly small, some full-range.
        for (int i = 0; i < 60; i++) begin
            v = (i % 4 == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 400));
            do_run(v);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
